// File: rtl/transmitter_block_if.sv
// transmitter_block_if: command, Avalon-MM and read-return signals of the transmitter block
interface transmitter_block_if #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 128
);
  logic              trans_valid_i;
  logic              trans_type_i;
  logic [ADDR_W-1:0] trans_addr_i;
  logic              trans_ready_o;
  logic              trans_busy_o;
  logic [ADDR_W-1:0] amm_address_o;
  logic              amm_write_o;
  logic              amm_read_o;
  logic [DATA_W-1:0] amm_writedata_o;
  logic [DATA_W/8-1:0] amm_byteenable_o;
  logic              amm_waitrequest_i;
  logic              amm_readdatavalid_i;
  logic [DATA_W-1:0] amm_readdata_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_unexp_o;
  modport master (
    input  trans_valid_i, trans_type_i, trans_addr_i,
    input  amm_waitrequest_i, amm_readdatavalid_i, amm_readdata_i,
    output trans_ready_o, trans_busy_o,
    output amm_address_o, amm_write_o, amm_read_o, amm_writedata_o, amm_byteenable_o,
    output rd_valid_o, rd_data_o, rd_addr_o, rd_unexp_o
  );
  modport slave (
    output trans_valid_i, trans_type_i, trans_addr_i,
    output amm_waitrequest_i, amm_readdatavalid_i, amm_readdata_i,
    input  trans_ready_o, trans_busy_o,
    input  amm_address_o, amm_write_o, amm_read_o, amm_writedata_o, amm_byteenable_o,
    input  rd_valid_o, rd_data_o, rd_addr_o, rd_unexp_o
  );
endinterface

// File: rtl/transmitter_block.sv
// transmitter_block: turns controller commands into single-word Avalon-MM accesses and tags read returns with their address
module transmitter_block #(
  parameter int ADDR_W      = 31,
  parameter int DATA_W      = 128,
  parameter int MAX_PEND_RD = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pattern_mode_i,
  input  logic [7:0]          pattern_byte_i,
  transmitter_block_if.master bus
);
  localparam int CW = $clog2(MAX_PEND_RD + 1);
  localparam int PW = $clog2(MAX_PEND_RD);
  typedef enum logic [1:0] {IDLE_S, WRITE_S, READ_S} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d, pop_addr;
  logic              write_q, write_d, read_q, read_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_eff;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] fifo_q [MAX_PEND_RD];
  logic              rd_valid_q, rd_valid_d, unexp_q, unexp_d;
  logic              ready, accept, done, issue_done, pop;
  always_comb begin
    cnt_eff    = cnt_q + CW'(state_q == READ_S);
    ready      = (state_q == IDLE_S) && (cnt_eff < CW'(MAX_PEND_RD));
    accept     = ready && bus.trans_valid_i;
    done       = (state_q != IDLE_S) && !bus.amm_waitrequest_i;
    issue_done = done && (state_q == READ_S);
    // with nothing queued, a read finishing this cycle is returned directly
    pop        = bus.amm_readdatavalid_i && ((cnt_q != '0) || issue_done);
    pop_addr   = (cnt_q == '0) ? addr_q : fifo_q[rd_ptr_q];
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    read_d     = read_q;
    wdata_d    = wdata_q;
    if (accept) begin
      state_d = bus.trans_type_i ? READ_S : WRITE_S;
      addr_d  = bus.trans_addr_i;
      write_d = !bus.trans_type_i;
      read_d  = bus.trans_type_i;
      wdata_d = pattern_mode_i ? {(DATA_W/32){32'(bus.trans_addr_i)}}
                               : {(DATA_W/8){pattern_byte_i}};
    end
    if (done) begin
      state_d = IDLE_S;
      write_d = 1'b0;
      read_d  = 1'b0;
    end
    cnt_d      = cnt_q + CW'(issue_done) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(issue_done);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    rd_valid_d = pop;
    rd_data_d  = pop ? bus.amm_readdata_i : rd_data_q;
    rd_addr_d  = pop ? pop_addr : rd_addr_q;
    unexp_d    = unexp_q || (bus.amm_readdatavalid_i && !pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE_S;
      addr_q     <= '0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      unexp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      unexp_q    <= unexp_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (issue_done) fifo_q[wr_ptr_q] <= addr_q;
  end
  assign bus.trans_ready_o    = ready;
  assign bus.trans_busy_o     = (state_q != IDLE_S) || (cnt_q != '0) || rd_valid_q;
  assign bus.amm_address_o    = addr_q;
  assign bus.amm_write_o      = write_q;
  assign bus.amm_read_o       = read_q;
  assign bus.amm_writedata_o  = wdata_q;
  assign bus.amm_byteenable_o = '1;
  assign bus.rd_valid_o       = rd_valid_q;
  assign bus.rd_data_o        = rd_data_q;
  assign bus.rd_addr_o        = rd_addr_q;
  assign bus.rd_unexp_o       = unexp_q;
endmodule
